// File: rtl/spn_round_ctrl_if.sv
// Block handshake bundle for spn_round_ctrl: plaintext/key in, ciphertext out.
// The master drives the offer and the consumer ready; the slave is the controller.
interface spn_round_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [WIDTH-1:0] key;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, key, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, key, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/spn_round_ctrl.sv
// Iterative SPN round sequencer sharing one external SubsLayer across all rounds.
// Define SPN_PIPE_REG_EN to split each round into key-mix and substitute cycles.
module spn_round_ctrl #(
    parameter int WIDTH  = 16,
    parameter int ROUNDS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    spn_round_ctrl_if.slave      bus,
    output logic                 busy,
    output logic [WIDTH-1:0]     sl_original,
    input  logic [WIDTH-1:0]     sl_substituted
);

    localparam int CW = $clog2(ROUNDS + 1);
    typedef logic [CW-1:0] cnt_t;

    typedef enum logic [2:0] {
        IDLE,
        ROUND,
`ifdef SPN_PIPE_REG_EN
        SUB,
`endif
        FINAL,
        DONE
    } state_t;

    state_t           state;
    cnt_t             r;
    logic [WIDTH-1:0] state_reg;
    logic [WIDTH-1:0] key_reg;
    logic [WIDTH-1:0] out_data_q;
    logic             out_valid_q;

    function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] v, input int amt);
        logic [WIDTH-1:0] res;
        res = '0;
        for (int i = 0; i < WIDTH; i++) res[(i + amt) % WIDTH] = v[i];
        return res;
    endfunction

    // Bit i moves to (4*i) mod (WIDTH-1); the top bit is a fixed point.
    function automatic logic [WIDTH-1:0] perm(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] p;
        p = '0;
        p[WIDTH-1] = v[WIDTH-1];
        for (int i = 0; i < WIDTH - 1; i++) p[(4 * i) % (WIDTH - 1)] = v[i];
        return p;
    endfunction

    logic [WIDTH-1:0] round_key;
    logic             last_round;
    logic [WIDTH-1:0] round_out;

    assign round_key  = rotl(key_reg, int'(r));
    assign last_round = (r == cnt_t'(ROUNDS - 1));
    assign round_out  = last_round ? sl_substituted : perm(sl_substituted);

    assign bus.in_ready  = (state == IDLE);
    assign busy          = (state != IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

`ifdef SPN_PIPE_REG_EN
    logic [WIDTH-1:0] pipe_reg;

    // Cleared after each SUB so the shared S-box input is quiet outside a round.
    assign sl_original = pipe_reg;
`else
    assign sl_original = (state == ROUND) ? (state_reg ^ round_key) : '0;
`endif

    // NOTE: every register here updates with <= so all reads see pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            r           <= '0;
            state_reg   <= '0;
            key_reg     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
`ifdef SPN_PIPE_REG_EN
            pipe_reg    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        state_reg <= bus.in_data;
                        key_reg   <= bus.key;
                        r         <= '0;
                        state     <= ROUND;
                    end
                end
`ifdef SPN_PIPE_REG_EN
                ROUND: begin
                    pipe_reg <= state_reg ^ round_key;
                    state    <= SUB;
                end
                SUB: begin
                    state_reg <= round_out;
                    pipe_reg  <= '0;
                    r         <= r + cnt_t'(1);
                    state     <= last_round ? FINAL : ROUND;
                end
`else
                ROUND: begin
                    state_reg <= round_out;
                    r         <= r + cnt_t'(1);
                    state     <= last_round ? FINAL : ROUND;
                end
`endif
                FINAL: begin
                    out_data_q  <= state_reg ^ round_key;
                    out_valid_q <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spn_round_ctrl.sv
// Directed bench for spn_round_ctrl with identity and inverting SubsLayer stubs.
// Expected ciphertexts are hand-derived; latency adapts to SPN_PIPE_REG_EN.
module tb_spn_round_ctrl;

    localparam int WIDTH  = 16;
    localparam int ROUNDS = 4;
`ifdef SPN_PIPE_REG_EN
    localparam int LAT = 2 * ROUNDS + 1;
`else
    localparam int LAT = ROUNDS + 1;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             busy;
    logic [WIDTH-1:0] sl_original;
    logic [WIDTH-1:0] sl_substituted;
    logic             invert = 1'b0;

    int tests  = 0;
    int failed = 0;

    spn_round_ctrl_if #(.WIDTH(WIDTH)) bus ();

    spn_round_ctrl #(.WIDTH(WIDTH), .ROUNDS(ROUNDS)) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus),
        .busy           (busy),
        .sl_original    (sl_original),
        .sl_substituted (sl_substituted)
    );

    assign sl_substituted = invert ? ~sl_original : sl_original;

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic start_block(input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] k);
        @(negedge clk);
        check("accept_ready", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.key      = k;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("accept_busy", 32'(busy), 32'd1);
    endtask

    task automatic wait_output(input string tag);
        int cycles;
        cycles = 0;
        while (!bus.out_valid && cycles < 40) begin
            if (cycles == LAT - 1) check({tag, "_sl_final"}, 32'(sl_original), 32'd0);
            @(posedge clk);
            #1;
            cycles++;
        end
        check({tag, "_latency"}, 32'(cycles), 32'(LAT));
    endtask

    task automatic release_output(input string tag);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check({tag, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_ready_back"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.key       = '0;
        bus.out_ready = 1'b0;

        #12;
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_busy",      32'(busy),          32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data",  32'(bus.out_data),  32'd0);
        check("rst_sl_orig",   32'(sl_original),   32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Identity stub, key 1: rounds give 0001, 0011, 0103, 010B; final ^0010.
        start_block(16'h0000, 16'h0001);
        wait_output("t1");
        check("t1_data",    32'(bus.out_data), 32'h011B);
        check("t1_sl_done", 32'(sl_original),  32'd0);
        release_output("t1");

        // Bits 0 and 15 are fixed points of P.
        start_block(16'h8001, 16'h0000);
        wait_output("t2");
        check("t2_data", 32'(bus.out_data), 32'h8001);
        release_output("t2");

        // Four inversions cancel out.
        invert = 1'b1;
        check("t3_sl_idle", 32'(sl_original), 32'd0);
        start_block(16'h0000, 16'h0000);
        wait_output("t3");
        check("t3_data",    32'(bus.out_data), 32'h0000);
        check("t3_sl_done", 32'(sl_original),  32'd0);
        release_output("t3");
        invert = 1'b0;

        // Backpressure with a stray offer while DONE.
        start_block(16'h0000, 16'h0001);
        wait_output("t4");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t4_hold_valid", 32'(bus.out_valid), 32'd1);
            check("t4_hold_data",  32'(bus.out_data),  32'h011B);
            check("t4_hold_ready", 32'(bus.in_ready),  32'd0);
            bus.in_valid = (i == 3);
            bus.in_data  = 16'hFFFF;
            bus.key      = 16'h1234;
        end
        bus.in_valid = 1'b0;
        release_output("t4");
        @(posedge clk);
        #1;
        check("t4_no_capture", 32'(busy), 32'd0);

        // Asynchronous reset in the middle of a block.
        start_block(16'h0000, 16'h0001);
        @(posedge clk);
        #2;
        check("t5_busy_pre", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        check("t5_rst_busy",      32'(busy),          32'd0);
        check("t5_rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("t5_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("t5_rst_out_data",  32'(bus.out_data),  32'd0);
        check("t5_rst_sl_orig",   32'(sl_original),   32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("t5_no_output", 32'(bus.out_valid), 32'd0);
        start_block(16'h0000, 16'h0001);
        wait_output("t5");
        check("t5_data", 32'(bus.out_data), 32'h011B);
        release_output("t5");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/spn_round_ctrl.md
# spn_round_ctrl

Iterative round sequencer for the SPN cipher datapath. It accepts one plaintext block and key over a valid/ready handshake and time-multiplexes a single external `SubsLayer` instance across all rounds. Key mixing, bit permutation and the round counter are internal. It returns the ciphertext over a second valid/ready handshake.

## Interface
- `WIDTH`, 16: block width in bits; matches the `size` define; multiple of 4.
- `ROUNDS`, 4: number of S-box rounds; must be ≥1.
- `clk`  in  1  clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low reset; clock and reset are fixed as exactly this: one clock, asynchronous active-low reset.
- `in_valid`  in  1  plaintext/key offered.
- `in_ready`  out  1  controller can accept (high only in IDLE).
- `in_data`  in  WIDTH  plaintext.
- `key`  in  WIDTH  cipher key; sampled on accept.
- `out_valid`  out  1  ciphertext available.
- `out_ready`  in  1  consumer accepts ciphertext.
- `out_data`  out  WIDTH  ciphertext; held stable while `out_valid`.
- `busy`  out  1  high in any state other than IDLE.
- `sl_original`  out  WIDTH  to shared SubsLayer `.original`.
- `sl_substituted`  in  WIDTH  from SubsLayer `.substituted`; treated as combinational.

## Operation
- States: IDLE, ROUND, (SUB, only with `SPN_PIPE_REG_EN`), FINAL, DONE.
- Round key: `rk_r = rotl(key_reg, r)` for r = 0..ROUNDS; `key_reg` is captured on accept.
- Permutation P: output bit `(4*i) mod (WIDTH-1)` takes input bit i for i < WIDTH-1; bit WIDTH-1 maps to itself.
- IDLE: `in_ready`=1. On `in_valid && in_ready`: `state_reg` ← `in_data`, `key_reg` ← `key`, `r` ← 0, go to ROUND.
- ROUND: `sl_original = state_reg ^ rk_r`.
  - If r < ROUNDS-1: `state_reg` ← P(`sl_substituted`).
  - If r = ROUNDS-1: `state_reg` ← `sl_substituted`, with no permutation.
  - `r` increments. After round ROUNDS-1, go to FINAL.
- FINAL: `out_data` register ← `state_reg ^ rk_ROUNDS`; `out_valid` ← 1; go to DONE.
- DONE: hold `out_data`/`out_valid` until `out_ready`. On `out_ready`: `out_valid` ← 0, go to IDLE. A new block is accepted no earlier than the following cycle.
- `sl_original` is 0 outside ROUND (and SUB), so the shared S-box sees no toggling.
- `in_valid` while not in IDLE: ignored; no capture and no side effects.
- Round counter width: `$clog2(ROUNDS+1)`. It never wraps, because the FSM leaves ROUND at `r`=ROUNDS-1.
- Reset (asynchronous, any state, mid-operation included): state IDLE, `r`=0, `state_reg`/`key_reg`/`out_data`=0, `out_valid`=0, `busy`=0, `in_ready`=1 after release. An in-flight block is discarded with no output.

## Timing
- Accept at edge 0. Round r completes at edge r+1. FINAL is registered at edge ROUNDS+1, so `out_valid` is high ROUNDS+1 cycles after accept (5 by default).
- With `SPN_PIPE_REG_EN`: 2 cycles per round, so `out_valid` is high 2·ROUNDS+1 cycles after accept.
- `out_ready` high in the first `out_valid` cycle: `out_valid` drops next edge and `in_ready` rises the same edge. Minimum issue interval is ROUNDS+3 cycles.
- `in_ready` and `busy` are decoded from registered state only; no combinational path from `in_valid`/`out_ready`.

## Configuration
- `SPN_PIPE_REG_EN` defined:
  - ROUND registers `state_reg ^ rk_r` into a pipeline register that drives `sl_original`.
  - SUB then captures P(`sl_substituted`) (or the unpermuted value on the last round) and increments `r`.
  - This breaks the key-XOR → S-box → P path into two cycles.
- Undefined: single-cycle rounds as described; no pipeline register exists.

## Test plan
- Identity S-box stub (`sl_substituted = sl_original`), `in_data`=16'h0000, `key`=16'h0001 → `out_data`=16'h011B, `out_valid` rising exactly 5 cycles after accept.
- Identity stub, `key`=0, `in_data`=16'h8001 (fixed points of P) → `out_data`=16'h8001.
- Inverting stub (`~sl_original`), `key`=0, `in_data`=16'h0000 → 16'h0000 after four inversions. Also check `sl_original` = 0 in IDLE/FINAL/DONE.
- Backpressure: hold `out_ready`=0 for 10 cycles → `out_valid`=1 and `out_data` constant throughout, `in_ready`=0. Pulse `in_valid` with new data during that window → result unchanged, no second capture.
- Reset asserted at round 2 → all outputs at reset values immediately (asynchronous). After release, `in_ready`=1; next block (16'h0000/16'h0001, identity stub) → 16'h011B.
- With `SPN_PIPE_REG_EN`: repeat the first scenario → 16'h011B with `out_valid` rising 9 cycles after accept.
